// File: rtl/cs_address_sequencer.sv
// Microprogram sequencer: owns the control-store address register, produces the
// CSAR+1 and branch-select inputs of the address mux, and stalls on memory accesses.
module cs_address_sequencer #(
  parameter int Direction_BUS_WIDTH = 11,
  parameter int Cond_BUS_WIDTH      = 3,
  parameter int Selection_BUS_WIDTH = 2
) (
  input  logic                           CS_Address_Sequencer_CLOCK_50,
  input  logic                           CS_Address_Sequencer_RESET_InHigh,
  input  logic                           CS_Address_Sequencer_Start_IN,
  input  logic                           CS_Address_Sequencer_Halt_IN,
  input  logic [Direction_BUS_WIDTH-1:0] CS_Address_Sequencer_Address_IN,
  input  logic [Cond_BUS_WIDTH-1:0]      CS_Address_Sequencer_Cond_IN,
  input  logic [3:0]                     CS_Address_Sequencer_Flags_IN,
  input  logic                           CS_Address_Sequencer_IR13_IN,
  input  logic                           CS_Address_Sequencer_MemReq_IN,
  input  logic                           CS_Address_Sequencer_MemDone_IN,
  output logic [Direction_BUS_WIDTH-1:0] CS_Address_Sequencer_CSAR_OUT,
  output logic [Direction_BUS_WIDTH-1:0] CS_Address_Sequencer_Next_OUT,
  output logic [Selection_BUS_WIDTH-1:0] CS_Address_Sequencer_Selection_OUT,
  output logic                           CS_Address_Sequencer_Running_OUT,
  output logic                           CS_Address_Sequencer_Waiting_OUT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [Selection_BUS_WIDTH-1:0] SEL_NEXT   = Selection_BUS_WIDTH'(0);
  localparam logic [Selection_BUS_WIDTH-1:0] SEL_JUMP   = Selection_BUS_WIDTH'(1);
  localparam logic [Selection_BUS_WIDTH-1:0] SEL_DECODE = Selection_BUS_WIDTH'(2);

  state_t                         state_q, state_d;
  logic [Direction_BUS_WIDTH-1:0] csar_q, csar_d;

  logic flag_n, flag_z, flag_v, flag_c;
  assign {flag_n, flag_z, flag_v, flag_c} = CS_Address_Sequencer_Flags_IN;

  always_ff @(posedge CS_Address_Sequencer_CLOCK_50) begin
    if (CS_Address_Sequencer_RESET_InHigh) begin
      state_q <= S_IDLE;
      csar_q  <= '0;
    end else begin
      state_q <= state_d;
      csar_q  <= csar_d;
    end
  end

  // Halt outranks memory handshakes in both RUN and WAIT; a late MemDone is dropped.
  always_comb begin
    state_d = state_q;
    csar_d  = csar_q;
    unique case (state_q)
      S_IDLE: begin
        if (CS_Address_Sequencer_Start_IN) state_d = S_RUN;
      end
      S_RUN: begin
        if (CS_Address_Sequencer_Halt_IN) begin
          state_d = S_IDLE;
        end else if (CS_Address_Sequencer_MemReq_IN && !CS_Address_Sequencer_MemDone_IN) begin
          state_d = S_WAIT;
        end else begin
          csar_d = CS_Address_Sequencer_Address_IN;
        end
      end
      S_WAIT: begin
        if (CS_Address_Sequencer_Halt_IN) begin
          state_d = S_IDLE;
        end else if (CS_Address_Sequencer_MemDone_IN) begin
          state_d = S_RUN;
          csar_d  = CS_Address_Sequencer_Address_IN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    CS_Address_Sequencer_Selection_OUT = SEL_NEXT;
    unique case (CS_Address_Sequencer_Cond_IN)
      3'd1: if (flag_n) CS_Address_Sequencer_Selection_OUT = SEL_JUMP;
      3'd2: if (flag_z) CS_Address_Sequencer_Selection_OUT = SEL_JUMP;
      3'd3: if (flag_v) CS_Address_Sequencer_Selection_OUT = SEL_JUMP;
      3'd4: if (flag_c) CS_Address_Sequencer_Selection_OUT = SEL_JUMP;
      3'd5: if (CS_Address_Sequencer_IR13_IN) CS_Address_Sequencer_Selection_OUT = SEL_JUMP;
      3'd6: CS_Address_Sequencer_Selection_OUT = SEL_JUMP;
      3'd7: CS_Address_Sequencer_Selection_OUT = SEL_DECODE;
      default: CS_Address_Sequencer_Selection_OUT = SEL_NEXT;
    endcase
  end

  assign CS_Address_Sequencer_CSAR_OUT    = csar_q;
  assign CS_Address_Sequencer_Next_OUT    = csar_q + Direction_BUS_WIDTH'(1);
  assign CS_Address_Sequencer_Running_OUT = (state_q == S_RUN);
  assign CS_Address_Sequencer_Waiting_OUT = (state_q == S_WAIT);

endmodule

// File: doc/cs_address_sequencer.md
# cs_address_sequencer

Microprogram sequencer for the micro-datapath control unit, directly downstream of the control-store address multiplexer. It holds the control-store address register (CSAR) that addresses the microcode ROM, produces the CSAR+1 "next" address and the 2-bit branch selection that the address multiplexer consumes, and latches the multiplexer's chosen address each cycle. It also stalls the microprogram while a memory access is pending and supports start/halt of the microengine.

## Interface
Parameters:
- Direction_BUS_WIDTH, 11, control-store address width.
- Cond_BUS_WIDTH, 3, width of the microinstruction COND field.
- Selection_BUS_WIDTH, 2, width of the mux selection code.

Ports:
- CS_Address_Sequencer_CLOCK_50  in  1  single system clock; all state updates on its rising edge.
- CS_Address_Sequencer_RESET_InHigh  in  1  reset, synchronous and active-high.
- CS_Address_Sequencer_Start_IN  in  1  leave IDLE and begin executing microcode.
- CS_Address_Sequencer_Halt_IN  in  1  return to IDLE (microinstruction halt bit).
- CS_Address_Sequencer_Address_IN  in  Direction_BUS_WIDTH  address chosen by the address mux.
- CS_Address_Sequencer_Cond_IN  in  Cond_BUS_WIDTH  COND field of the current microinstruction.
- CS_Address_Sequencer_Flags_IN  in  4  PSR flags {n,z,v,c}, bit 3 = n.
- CS_Address_Sequencer_IR13_IN  in  1  bit 13 of the instruction register.
- CS_Address_Sequencer_MemReq_IN  in  1  current microinstruction performs a memory read/write.
- CS_Address_Sequencer_MemDone_IN  in  1  memory completion, one-cycle pulse.
- CS_Address_Sequencer_CSAR_OUT  out  Direction_BUS_WIDTH  registered control-store address.
- CS_Address_Sequencer_Next_OUT  out  Direction_BUS_WIDTH  CSAR_OUT+1, to mux Next input.
- CS_Address_Sequencer_Selection_OUT  out  Selection_BUS_WIDTH  mux select: 00 next, 01 jump, 10 decode.
- CS_Address_Sequencer_Running_OUT  out  1  high in RUN.
- CS_Address_Sequencer_Waiting_OUT  out  1  high in WAIT.

## Operation
- Selection_OUT is combinational from Cond_IN, Flags_IN and IR13_IN, in every state:
  - 000 → 00.
  - 001/010/011/100 → 01 if n/z/v/c respectively is 1, otherwise 00.
  - 101 → 01 if IR13=1, otherwise 00.
  - 110 → 01.
  - 111 → 10.
  - Code 11 is never produced.
- Next_OUT = CSAR_OUT+1, truncated to Direction_BUS_WIDTH. It is combinational and wraps, so 2047 gives 0.
- FSM states: IDLE, RUN, WAIT. The priority order in every state is reset > Halt > memory > advance.
  - IDLE: CSAR held. Start_IN=1 → RUN, with CSAR unchanged. This means the first microinstruction executed is the one at the held CSAR (0 after reset).
  - RUN, Halt_IN=1: → IDLE, CSAR held.
  - RUN, MemReq_IN=0: CSAR ← Address_IN, stay in RUN.
  - RUN, MemReq_IN=1 and MemDone_IN=1: CSAR ← Address_IN, stay in RUN (zero-wait access).
  - RUN, MemReq_IN=1 and MemDone_IN=0: → WAIT, CSAR held.
  - WAIT, MemDone_IN=1: CSAR ← Address_IN, → RUN. The branch is evaluated with the flags present in that cycle.
  - WAIT, MemDone_IN=0: hold.
  - WAIT, Halt_IN=1: → IDLE, CSAR held; the pending MemDone is discarded.
- Start_IN is ignored outside IDLE. MemDone_IN is ignored in IDLE, and in RUN when MemReq_IN=0.
- Running_OUT and Waiting_OUT are decoded from the state register, so they change only at clock edges.

## Timing
- Reset: on a rising edge with RESET_InHigh=1, the block enters IDLE, CSAR_OUT=0, Running_OUT=0, Waiting_OUT=0. Consequently Next_OUT=1 and Selection_OUT follows its inputs.
- Reset wins over every simultaneous event, including MemDone in WAIT and Start in IDLE.
- Address latency: an Address_IN sampled at edge k appears on CSAR_OUT after edge k. The mux→CSAR loop is one cycle per microinstruction.
- Selection_OUT and Next_OUT are purely combinational, with no added latency. The loop through the mux is combinational from CSAR_OUT, and is broken only by the CSAR register.
- The number of WAIT cycles equals the number of edges until MemDone_IN; there is no timeout.

## Test plan
- **Reset/start:** assert reset mid-WAIT with CSAR=0x123 → next cycle IDLE, CSAR=0, Next=1, Running=0, Waiting=0. Then Start=1 with Cond=000 and Address_IN=0x001 → RUN after 1 edge, CSAR=0x001 after 2 edges.
- **Branch decode:** sweep Cond 000–111 against each flag value and IR13 value. Required: Selection 00 or 01 per the table above, 110→01, 111→10, and 11 never observed.
- **Memory stall:** in RUN, MemReq=1 and MemDone=0 with Address_IN=0x050 → WAIT with CSAR held for 3 cycles. MemDone pulse on cycle 4 → CSAR=0x050, RUN, Waiting=0. Repeat with MemReq=MemDone=1 in the same cycle → no WAIT entry.
- **Wrap:** hold CSAR=0x7FF in IDLE → Next_OUT=0x000. Start with Address_IN=Next_OUT → CSAR=0x000.
- **Priorities:** Halt=1 with MemReq=1 in RUN → IDLE, CSAR held. Start=1 while in RUN → no effect. Halt=1 and MemDone=1 in WAIT → IDLE, CSAR held.
